// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide
// sequencer.
//   md_op_t    - operation code carried on the request bus. The encodings
//                3'b110 and 3'b111 are reserved and deliberately left unnamed.
//   md_state_t - sequencer FSM states.
//   CNT_W      - iteration counter width for the default operand width.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // The counter must be able to hold the value WIDTH itself, which needs
    // one more bit than $clog2(WIDTH).
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_width(MD_WIDTH);

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: core <-> multiply/divide sequencer bus.
//   master (core):  drives start, op, a, b, rd_hilo; observes busy, done,
//                   stall, hi, lo.
//   slave (block):  the reverse direction.
interface muldiv_seq_if #(parameter int WIDTH = muldiv_pkg::MD_WIDTH);

    logic                start;
    muldiv_pkg::md_op_t  op;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                rd_hilo;
    logic                busy;
    logic                done;
    logic                stall;
    logic [WIDTH-1:0]    hi;
    logic [WIDTH-1:0]    lo;

    modport master (output start, op, a, b, rd_hilo,
                    input  busy, done, stall, hi, lo);
    modport slave  (input  start, op, a, b, rd_hilo,
                    output busy, done, stall, hi, lo);

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the sequencer.
//   is_div - 0: radix-2 shift-add multiply, 1: restoring shift-subtract divide
//   acc    - 2*WIDTH accumulator. Multiply: {partial product, multiplier}.
//            Divide: the low half holds the dividend, which shifts out MSB
//            first while quotient bits shift in at the bottom.
//   rem    - WIDTH+1 partial remainder (divide only)
//   opnd   - multiplicand (multiply) or divisor (divide) magnitude
//   acc_n, rem_n - values for the next iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH:0]       rem,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_n,
    output logic [WIDTH:0]       rem_n
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           unused_rem_msb;

    // Add the multiplicand into the upper half when the multiplier LSB is
    // set. The carry goes into bit WIDTH and is shifted back down below.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

    // The remainder is always below the divisor, so its WIDTH low bits plus
    // the next dividend bit fit exactly in WIDTH+1 bits. A set MSB in the
    // difference means a borrow, so the subtraction is discarded.
    assign div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    assign unused_rem_msb = rem[WIDTH];

    always_comb begin
        acc_n = acc;
        rem_n = rem;
        if (is_div) begin
            acc_n = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~div_diff[WIDTH]};
            rem_n = div_diff[WIDTH] ? div_shift : div_diff;
        end else begin
            acc_n = {mul_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer with the architectural
// HI/LO registers.
//   clk, reset - core clock; synchronous active-high reset
//   bus        - muldiv_seq_if.slave:
//                start/op/a/b  issue MULT/MULTU/DIV/DIVU/MTHI/MTLO
//                rd_hilo       core is executing MFHI/MFLO this cycle
//                busy          ITER or FIX
//                done          one-cycle pulse after HI/LO are written
//                stall         busy & (rd_hilo | start)
//                hi, lo        HI/LO registers
// Multiply and divide run on operand magnitudes for WIDTH iterations. A final
// FIX cycle applies the result signs and writes HI/LO.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_seq_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    md_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_q, a_d;       // raw dividend, returned on divide-by-zero
    logic               is_div_q, is_div_d;
    logic               sign_q, sign_d;  // product / quotient sign
    logic               rsign_q, rsign_d; // remainder sign
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH:0]     step_rem;

    logic               op_signed, op_div;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_mag, rem_mag;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_q),
        .acc    (acc_q),
        .rem    (rem_q),
        .opnd   (opnd_q),
        .acc_n  (step_acc),
        .rem_n  (step_rem)
    );

    assign op_signed = (bus.op == MD_MULT) || (bus.op == MD_DIV);
    assign op_div    = (bus.op == MD_DIV)  || (bus.op == MD_DIVU);
    // The most negative value maps onto itself, and read as unsigned that is
    // its correct magnitude. This is why DIV overflow needs no special case.
    assign a_mag     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign prod_fix  = sign_q ? -acc_q : acc_q;
    assign quot_mag  = acc_q[WIDTH-1:0];
    assign rem_mag   = rem_q[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        a_d      = a_q;
        is_div_d = is_div_q;
        sign_d   = sign_q;
        rsign_d  = rsign_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        MD_MTHI: hi_d = bus.a;
                        MD_MTLO: lo_d = bus.a;
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            is_div_d = op_div;
                            // The multiplier or dividend goes in the low
                            // half and is consumed one bit per iteration.
                            acc_d    = {{WIDTH{1'b0}}, op_div ? a_mag : b_mag};
                            opnd_d   = op_div ? b_mag : a_mag;
                            rem_d    = '0;
                            a_d      = bus.a;
                            sign_d   = op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            rsign_d  = op_signed & bus.a[WIDTH-1];
                            dz_d     = op_div & (bus.b == '0);
                            cnt_d    = '0;
                            state_d  = ITER;
                        end
                        default: ;  // reserved encodings
                    endcase
                end
            end
            ITER: begin
                acc_d = step_acc;
                rem_d = step_rem;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = FIX;
            end
            FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (dz_q) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = sign_q  ? -quot_mag : quot_mag;
                    hi_d = rsign_q ? -rem_mag  : rem_mag;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            rsign_q  <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            a_q      <= a_d;
            is_div_q <= is_div_d;
            sign_q   <= sign_d;
            rsign_q  <= rsign_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.stall = bus.busy & (bus.rd_hilo | bus.start);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq. Results are checked
// against a plain-arithmetic model of MIPS HI/LO semantics.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(W)) bus ();

    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference: {hi, lo} from signed/unsigned 64-bit arithmetic.
    function automatic logic [63:0] model(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MD_MULT:  begin q = sa * sb; return q; end
            MD_MULTU: begin u = {32'd0, a} * {32'd0, b}; return u; end
            MD_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb; r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Issue one op and observe a fixed window. Cycle n is the cycle after
    // the n-th edge following the start edge.
    task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rhi, output logic [31:0] rlo,
                          output int lat, output int busy_cnt, output int done_cnt, output bit early);
        logic [31:0] hi0, lo0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        hi0 = bus.hi; lo0 = bus.lo;
        rhi = 'x; rlo = 'x; lat = 0; busy_cnt = 0; done_cnt = 0; early = 0;
        for (int n = 1; n <= W + 6; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (lat == 0) begin lat = n; rhi = bus.hi; rlo = bus.lo; end
            end
            if (lat == 0 && (bus.hi !== hi0 || bus.lo !== lo0)) early = 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.start = 1'b0; bus.rd_hilo = 1'b1;
        bus.op = MD_MULT; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        chk_cnt++; if ({bus.hi, bus.lo} !== 64'd0) $display("FAIL reset_hilo got %h want 0", {bus.hi, bus.lo}); else pass_cnt++;
        chk_cnt++; if ({bus.busy, bus.done, bus.stall} !== 3'b000) $display("FAIL reset_flags got %b want 000", {bus.busy, bus.done, bus.stall}); else pass_cnt++;
        reset = 1'b0; bus.rd_hilo = 1'b0;
    endtask

    task automatic test_mthi_mtlo();
        logic [2:0] rsv;
        @(negedge clk); bus.start = 1'b1; bus.op = MD_MTHI; bus.a = 32'h1234;
        @(negedge clk); bus.op = MD_MTLO; bus.a = 32'h5678;
        chk_cnt++; if (bus.hi !== 32'h1234 || bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL mthi got hi=%h busy=%b done=%b want 1234/0/0", bus.hi, bus.busy, bus.done); else pass_cnt++;
        @(negedge clk); rsv = 3'b110; bus.op = md_op_t'(rsv); bus.a = 32'hDEAD;
        chk_cnt++; if ({bus.hi, bus.lo} !== {32'h1234, 32'h5678} || bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL mtlo got %h_%h busy=%b done=%b", bus.hi, bus.lo, bus.busy, bus.done); else pass_cnt++;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        chk_cnt++; if ({bus.hi, bus.lo} !== {32'h1234, 32'h5678} || bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reserved_op got %h_%h busy=%b done=%b", bus.hi, bus.lo, bus.busy, bus.done); else pass_cnt++;
    endtask

    task automatic test_directed();
        md_op_t      ops[5] = '{MD_MULTU, MD_MULT, MD_DIV, MD_DIVU, MD_DIV};
        logic [31:0] av[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
        logic [31:0] bv[5]  = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] eh[5]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd0};
        logic [31:0] el[5]  = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] rhi, rlo;
        int lat, bc, dc;
        bit early;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], av[i], bv[i], rhi, rlo, lat, bc, dc, early);
            chk_cnt++; if ({rhi, rlo} !== {eh[i], el[i]}) $display("FAIL directed%0d_result got %h_%h want %h_%h", i, rhi, rlo, eh[i], el[i]); else pass_cnt++;
            chk_cnt++; if (lat != W + 2 || dc != 1) $display("FAIL directed%0d_done got cycle=%0d pulses=%0d want %0d/1", i, lat, dc, W + 2); else pass_cnt++;
            chk_cnt++; if (bc != W + 1 || early) $display("FAIL directed%0d_busy got busy=%0d early=%0d want %0d/0", i, bc, early, W + 1); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        md_op_t      op;
        logic [31:0] a, b, rhi, rlo;
        logic [63:0] exp;
        int lat, bc, dc, bad;
        bit early;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            op = md_op_t'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 100);
            exp = model(op, a, b);
            run_op(op, a, b, rhi, rlo, lat, bc, dc, early);
            chk_cnt++; if ({rhi, rlo} !== exp) $display("FAIL random%0d op=%0d a=%h b=%h got %h_%h want %h", i, op, a, b, rhi, rlo, exp); else pass_cnt++;
            if (lat != W + 2 || dc != 1 || bc != W + 1 || early) bad++;
        end
        chk_cnt++; if (bad != 0) $display("FAIL random_timing got %0d bad ops want 0", bad); else pass_cnt++;
    endtask

    task automatic test_hazard();
        int stall_bad;
        stall_bad = 0;
        @(negedge clk);
        bus.rd_hilo = 1'b1; bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'd3; bus.b = 32'd4;
        for (int n = 1; n <= W + 4; n++) begin
            @(negedge clk);
            bus.start = (n == 5);
            if (n == 5) begin bus.op = MD_MULT; bus.a = 32'd100; bus.b = 32'd100; end
            #1;
            if (bus.stall !== (n <= W + 1)) stall_bad++;
            if (n == W + 2) begin
                chk_cnt++; if (bus.done !== 1'b1 || bus.stall !== 1'b0) $display("FAIL hazard_done_cycle got done=%b stall=%b want 1/0", bus.done, bus.stall); else pass_cnt++;
                chk_cnt++; if ({bus.hi, bus.lo} !== 64'd12) $display("FAIL hazard_read got %h_%h want 0_0000000c", bus.hi, bus.lo); else pass_cnt++;
            end
        end
        chk_cnt++; if (stall_bad != 0) $display("FAIL hazard_stall got %0d wrong cycles want 0", stall_bad); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0 || {bus.hi, bus.lo} !== 64'd12) $display("FAIL hazard_restart got busy=%b hilo=%h want 0/12", bus.busy, {bus.hi, bus.lo}); else pass_cnt++;
        bus.rd_hilo = 1'b0;
    endtask

    task automatic test_reset_mid();
        int dc, bc;
        dc = 0; bc = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = MD_DIVU; bus.a = 32'd1000; bus.b = 32'd7;
        for (int n = 1; n <= 10; n++) begin @(negedge clk); bus.start = 1'b0; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_cnt++; if (bus.busy !== 1'b0 || {bus.hi, bus.lo} !== 64'd0) $display("FAIL reset_mid got busy=%b hilo=%h want 0/0", bus.busy, {bus.hi, bus.lo}); else pass_cnt++;
        for (int n = 0; n < W + 6; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dc++;
            if (bus.busy === 1'b1) bc++;
        end
        chk_cnt++; if (dc != 0 || bc != 0 || {bus.hi, bus.lo} !== 64'd0) $display("FAIL reset_mid_quiet got done=%0d busy=%0d hilo=%h want 0/0/0", dc, bc, {bus.hi, bus.lo}); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_directed();
        test_random();
        test_hazard();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
